// File: rtl/cm_sort_gather.sv
// Word-serial to DCNT-wide frame gatherer feeding the parallel sorter.
// Optional short-frame support via i_last when CM_SORT_GATHER_LAST_EN is defined.
module cm_sort_gather #(
    parameter int unsigned DCNT     = 4,
    parameter int unsigned DWIDTH   = 8,
    parameter bit          PAD_HIGH = 1'b1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_vld,
    input  logic [DWIDTH-1:0]                i_data,
`ifdef CM_SORT_GATHER_LAST_EN
    input  logic                             i_last,
`endif
    output logic                             o_vld,
    output logic [DCNT-1:0][DWIDTH-1:0]      o_data,
    output logic [$clog2(DCNT+1)-1:0]        o_cnt
);

    localparam int unsigned CW = (DCNT > 1) ? $clog2(DCNT) : 1;
    localparam int unsigned OW = $clog2(DCNT + 1);

    logic [CW-1:0]                  cnt_q;
    logic [DCNT-1:0][DWIDTH-1:0]    buf_q;
    logic [DCNT-1:0][DWIDTH-1:0]    frame_d;
    logic [OW-1:0]                  cnt_out;
    logic                           full;
    logic                           close;

    assign full = (cnt_q == CW'(DCNT - 1));

`ifdef CM_SORT_GATHER_LAST_EN
    localparam logic [DWIDTH-1:0] PAD = {DWIDTH{PAD_HIGH}};

    assign close   = i_vld && (full || i_last);
    assign cnt_out = OW'(cnt_q) + OW'(1);

    // Slots below the fill point come from the buffer, the closing word lands at cnt_q,
    // everything above is padded so stale buffer contents never escape.
    always_comb begin
        frame_d = '0;
        for (int unsigned k = 0; k < DCNT; k++) begin
            if (k < 32'(cnt_q)) begin
                frame_d[k] = buf_q[k];
            end else if (k == 32'(cnt_q)) begin
                frame_d[k] = i_data;
            end else begin
                frame_d[k] = PAD;
            end
        end
    end
`else
    assign close   = i_vld && full;
    assign cnt_out = OW'(DCNT);

    always_comb begin
        frame_d         = buf_q;
        frame_d[DCNT-1] = i_data;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            buf_q  <= '0;
            o_vld  <= 1'b0;
            o_data <= '0;
            o_cnt  <= '0;
        end else begin
            o_vld <= 1'b0;
            if (i_vld) begin
                buf_q[cnt_q] <= i_data;
                if (close) begin
                    o_vld  <= 1'b1;
                    o_data <= frame_d;
                    o_cnt  <= cnt_out;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule
